// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle fetch/decode/execute/memory/write-back control FSM
// holding PC and IR, with bounded memory handshakes and a sticky fault state.
module instruction_sequencer #(
    parameter int unsigned         PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0] PC_RESET      = '0,
    parameter int unsigned         MEM_TIMEOUT   = 15,
    parameter logic [15:0]         RETIRED_RESET = 16'h0000
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    output logic                Fetch_Req,
    input  logic                Fetch_Ack,
    input  logic [31:0]         Fetch_Data,
    output logic [PC_WIDTH-1:0] PC,
    output logic [31:0]         IR,
    input  logic                NOP_FLAG,
    input  logic                IFNR_FLAG,
    input  logic [1:0]          Instruction_Format,
    input  logic [5:0]          Instruction_OP_Code,
    input  logic [25:0]         Instruction_Immediate,
    output logic                ALU_Start,
    output logic                Mem_Req,
    output logic                Mem_Write,
    input  logic                Mem_Ack,
    output logic                RegFile_Write_En,
    output logic                Fault,
    output logic [2:0]          State,
    output logic [15:0]         Retired_Count
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] OP_STORE = 6'b100011;
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [15:0]         retired_q, retired_d;
    logic [7:0]          wait_q, wait_d;
    logic                retire;
    logic                is_store;

    assign is_store      = Instruction_OP_Code == OP_STORE;
    assign PC            = pc_q;
    assign IR            = ir_q;
    assign State         = state_q;
    assign Retired_Count = retired_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            retired_q <= RETIRED_RESET;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    // Wait counter is zero outside FETCH/MEM, so every entry into those states starts from 0.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        wait_d    = '0;
        retire    = 1'b0;
        case (state_q)
            IDLE:   state_d = Run ? FETCH : IDLE;
            FETCH: begin
                if (Fetch_Ack) begin
                    ir_d    = Fetch_Data;
                    pc_d    = pc_q + PC_WIDTH'(4);
                    state_d = DECODE;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DECODE: begin
                if (IFNR_FLAG) begin
                    state_d = FAULT;
                end else if (NOP_FLAG) begin
                    retire = 1'b1;
                end else if (Instruction_Format == 2'd0 || Instruction_Format == 2'd1) begin
                    state_d = EXEC;
                end else if (Instruction_Format == 2'd2) begin
                    pc_d   = PC_WIDTH'(Instruction_Immediate);
                    retire = 1'b1;
                end else begin
                    state_d = FAULT;
                end
            end
            EXEC:   state_d = (Instruction_Format == 2'd1) ? MEM : WB;
            MEM: begin
                if (Mem_Ack) begin
                    retire  = is_store;
                    state_d = WB;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WB:     retire = 1'b1;
            FAULT:  state_d = FAULT;
            default: state_d = FAULT;
        endcase
        if (retire) begin
            retired_d = retired_q + 16'd1;
            state_d   = Run ? FETCH : IDLE;
        end
    end

    always_comb begin
        Fetch_Req        = state_q == FETCH;
        ALU_Start        = state_q == EXEC;
        Mem_Req          = state_q == MEM;
        Mem_Write        = (state_q == MEM) && is_store;
        RegFile_Write_En = state_q == WB;
        Fault            = state_q == FAULT;
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: randomized instruction stream with a per-instruction reference
// model feeding a scoreboard that a monitor drains at every retirement.
module tb_instruction_sequencer;
    localparam int TO = 15;
    localparam logic [5:0] LD = 6'b100010, ST = 6'b100011, JP = 6'b000010;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] cnt;
        int          cycles;
        int          alu_at;
        int          wb_at;
        int          mem_n;
        logic        mem_wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, run, fetch_ack, mem_ack;
    logic [31:0] fetch_data;
    logic        fetch_req, alu_start, mem_req, mem_write, wb_en, fault;
    logic [31:0] pc, ir;
    logic [2:0]  state;
    logic [15:0] rc;
    logic        w_fetch_req, w_alu_start, w_mem_req, w_mem_write, w_wb_en, w_fault;
    logic [31:0] w_pc, w_ir;
    logic [2:0]  w_state;
    logic [15:0] w_rc;
    logic        nop, ifnr;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [25:0] imm;

    exp_t        sb[$];
    logic [31:0] m_pc = '0;
    logic [15:0] m_cnt = '0;
    int          checks = 0, errors = 0;

    // Environment decoder: opcode 0 = reg-reg, load/store = format b, 000010 = jump.
    assign op   = ir[31:26];
    assign imm  = ir[25:0];
    assign nop  = ir == 32'h0000_003F;
    assign fmt  = (op == 6'd0) ? 2'd0 : (op == LD || op == ST) ? 2'd1 : (op == JP) ? 2'd2 : 2'd3;
    assign ifnr = fmt == 2'd3;

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .Clock(clk), .Reset(rst), .Run(run),
        .Fetch_Req(fetch_req), .Fetch_Ack(fetch_ack), .Fetch_Data(fetch_data),
        .PC(pc), .IR(ir), .NOP_FLAG(nop), .IFNR_FLAG(ifnr),
        .Instruction_Format(fmt), .Instruction_OP_Code(op), .Instruction_Immediate(imm),
        .ALU_Start(alu_start), .Mem_Req(mem_req), .Mem_Write(mem_write), .Mem_Ack(mem_ack),
        .RegFile_Write_En(wb_en), .Fault(fault), .State(state), .Retired_Count(rc)
    );

    // Twin with a preloaded counter so the 0xFFFF -> 0x0000 wrap is exercised early.
    instruction_sequencer #(.RETIRED_RESET(16'hFFFE)) dut_w (
        .Clock(clk), .Reset(rst), .Run(run),
        .Fetch_Req(w_fetch_req), .Fetch_Ack(fetch_ack), .Fetch_Data(fetch_data),
        .PC(w_pc), .IR(w_ir), .NOP_FLAG(nop), .IFNR_FLAG(ifnr),
        .Instruction_Format(fmt), .Instruction_OP_Code(op), .Instruction_Immediate(imm),
        .ALU_Start(w_alu_start), .Mem_Req(w_mem_req), .Mem_Write(w_mem_write), .Mem_Ack(mem_ack),
        .RegFile_Write_En(w_wb_en), .Fault(w_fault), .State(w_state), .Retired_Count(w_rc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_word(input int k);
        logic [25:0] r;
        r = 26'($urandom);
        case (k)
            0:       return (r == 26'h3F) ? 32'h0000_0040 : {6'd0, r};
            1:       return {LD, r};
            2:       return {ST, r};
            3:       return {JP, r};
            default: return 32'h0000_003F;
        endcase
    endfunction

    // Drives one instruction through the handshakes; fd/md are ack delays, md<0 withholds Mem_Ack.
    task automatic issue(input logic [31:0] w, input int fd, input int md);
        logic ld, st, jp, np, al;
        exp_t e;
        int   n;
        ld = w[31:26] == LD;
        st = w[31:26] == ST;
        jp = w[31:26] == JP;
        np = w == 32'h0000_003F;
        al = w[31:26] == 6'd0 && !np;
        if ((ld || st || jp || np || al) && md >= 0) begin
            e.pc     = jp ? {6'd0, w[25:0]} : m_pc + 32'd4;
            m_cnt    = m_cnt + 16'd1;
            e.cnt    = m_cnt;
            e.cycles = fd + 1 + ((np || jp) ? 1 : al ? 3 : ld ? md + 4 : md + 3);
            e.alu_at = (al || ld || st) ? fd + 3 : 0;
            e.wb_at  = al ? fd + 4 : ld ? fd + md + 5 : 0;
            e.mem_n  = (ld || st) ? md + 1 : 0;
            e.mem_wr = st;
            sb.push_back(e);
            m_pc = e.pc;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        n = 0;
        while (fetch_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (fetch_req !== 1'b1) begin chk("fetch_req_wait", 64'(fetch_req), 64'd1); return; end
        repeat (fd) @(negedge clk);
        fetch_ack = 1'b1;
        fetch_data = w;
        @(negedge clk);
        fetch_ack = 1'b0;
        fetch_data = $urandom;
        if ((ld || st) && md >= 0) begin
            n = 0;
            while (mem_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            if (mem_req !== 1'b1) begin chk("mem_req_wait", 64'(mem_req), 64'd1); return; end
            repeat (md) @(negedge clk);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 chk("rst_async_fault", 64'(fault), 64'd0);
        chk("rst_async_req", 64'(fetch_req), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        m_pc = '0;
        m_cnt = '0;
        @(negedge clk);
    endtask

    initial begin : monitor
        int          busy, alu_at, wb_at, alu_n, wb_n, mem_n;
        logic        mem_wr;
        logic [15:0] last_rc, wexp;
        exp_t        e;
        busy = 0; alu_at = 0; wb_at = 0; alu_n = 0; wb_n = 0; mem_n = 0; mem_wr = 1'b0;
        last_rc = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                busy = 0; alu_at = 0; wb_at = 0; alu_n = 0; wb_n = 0; mem_n = 0; mem_wr = 1'b0;
                last_rc = '0;
            end else begin
                if (rc !== last_rc) begin
                    if (sb.size() == 0) begin
                        chk("spurious_retire", 64'(rc), 64'(last_rc));
                    end else begin
                        e = sb.pop_front();
                        wexp = e.cnt + 16'hFFFE;
                        chk("retire_pc", 64'(pc), 64'(e.pc));
                        chk("retire_pc_twin", 64'(w_pc), 64'(e.pc));
                        chk("retired_count", 64'(rc), 64'(e.cnt));
                        chk("retired_count_wrap", 64'(w_rc), 64'(wexp));
                        chk("latency", 64'(busy), 64'(e.cycles));
                        chk("alu_start_cycle", 64'(alu_at), 64'(e.alu_at));
                        chk("alu_start_pulses", 64'(alu_n), (e.alu_at != 0) ? 64'd1 : 64'd0);
                        chk("wb_cycle", 64'(wb_at), 64'(e.wb_at));
                        chk("wb_pulses", 64'(wb_n), (e.wb_at != 0) ? 64'd1 : 64'd0);
                        chk("mem_req_cycles", 64'(mem_n), 64'(e.mem_n));
                        chk("mem_write", 64'(mem_wr), 64'(e.mem_wr));
                    end
                    last_rc = rc;
                    busy = 0; alu_at = 0; wb_at = 0; alu_n = 0; wb_n = 0; mem_n = 0; mem_wr = 1'b0;
                end
                if (state >= 3'd1 && state <= 3'd5) begin
                    busy++;
                    if (alu_start) begin alu_n++; alu_at = busy; end
                    if (wb_en) begin wb_n++; wb_at = busy; end
                    if (mem_req) begin mem_n++; mem_wr = mem_wr | mem_write; end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        rst = 1'b1; run = 1'b0; fetch_ack = 1'b0; mem_ack = 1'b0; fetch_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_pc", 64'(pc), 64'd0);
        chk("reset_ir", 64'(ir), 64'd0);
        chk("reset_count", 64'(rc), 64'd0);
        chk("reset_outputs", 64'({fetch_req, alu_start, mem_req, mem_write, wb_en, fault}), 64'd0);
        chk("reset_twin_count", 64'(w_rc), 64'hFFFE);
        chk("reset_twin_outputs", 64'({w_fetch_req, w_alu_start, w_mem_req, w_mem_write, w_wb_en, w_fault, w_state, w_ir}), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        run = 1'b1;
        n = 0;
        while (fetch_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("fetch_req_before_reset", 64'(fetch_req), 64'd1);
        #2 rst = 1'b1;
        #1 chk("midfetch_reset_req", 64'(fetch_req), 64'd0);
        chk("midfetch_reset_state", 64'(state), 64'd0);
        @(negedge clk);
        run = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_pc", 64'(pc), 64'd0);
        chk("post_reset_state", 64'(state), 64'd0);

        run = 1'b1;
        issue(rand_word(0), 0, 0);
        issue(rand_word(1), 0, 3);
        issue(rand_word(2), 0, 2);
        issue(32'h0800_0100, 0, 0);
        issue(32'h0000_003F, 0, 0);
        issue(rand_word(0), TO, 0);
        issue(rand_word(1), 0, TO);
        for (int i = 0; i < 60; i++)
            issue(rand_word(int'($urandom_range(0, 4))), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        issue(rand_word(0), 0, 0);
        @(negedge clk);
        chk("drop_run_exec_state", 64'(state), 64'd3);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_run_idle_state", 64'(state), 64'd0);
        chk("drop_run_no_fetch", 64'(fetch_req), 64'd0);
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        run = 1'b1;
        issue({6'b111111, 26'h0}, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("ifnr_fault", 64'(fault), 64'd1);
            chk("ifnr_twin_fault", 64'(w_fault), 64'd1);
            chk("ifnr_state", 64'(state), 64'd6);
            chk("ifnr_quiet", 64'({fetch_req, mem_req, alu_start, wb_en}), 64'd0);
            chk("ifnr_pc_frozen", 64'(pc), 64'(m_pc));
            fetch_ack = 1'($urandom);
            @(negedge clk);
        end
        fetch_ack = 1'b0;
        do_reset();

        n = 0;
        while (fetch_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (fault !== 1'b1 && n < 100) begin
            if (fetch_req === 1'b1) n++;
            @(negedge clk);
        end
        chk("fetch_timeout_cycles", 64'(n), 64'(TO + 1));
        chk("fetch_timeout_state", 64'(state), 64'd6);
        do_reset();

        issue(rand_word(1), 0, -1);
        n = 0;
        while (fault !== 1'b1 && n < 100) begin
            if (mem_req === 1'b1) n++;
            @(negedge clk);
        end
        chk("mem_timeout_cycles", 64'(n), 64'(TO + 1));
        chk("mem_timeout_pc", 64'(pc), 64'(m_pc));
        run = 1'b0;
        do_reset();
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("final_state", 64'(state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
